// File: rtl/riscv_fetch_unit.sv
// riscv_fetch_unit
//   Instruction-fetch front end. A PC register issues word requests to a
//   fixed-latency instruction memory. Each issued PC rides a MEM_LATENCY-deep
//   {valid, pc} pipeline, and the returning word is paired with it in an
//   instruction queue toward decode. Issue is credit-limited so the queue can
//   never overflow. Redirects flush the queue and squash in-flight responses.
//   Debug halt gates only delivery; single step lets exactly one instruction out.
//
// Ports
//   clk_in, rst_in        clock, asynchronous active-high reset
//   hlt_in, step_in       debug halt level, single-step pulse
//   redirect_valid_in     redirect fetch to redirect_pc_in (word aligned)
//   redirect_pc_in
//   inst_addr_out         instruction memory address (PC register)
//   inst_req_out          request issued this cycle
//   inst_data_in          word for the request MEM_LATENCY cycles after issue
//   fetch_valid_out       queue head offered to decode
//   fetch_ready_in        decode accepts the head
//   fetch_instr_out       head instruction word
//   fetch_pc_out          head PC

module riscv_fetch_unit #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          MEM_LATENCY = 1,
   parameter int          FIFO_DEPTH  = 4
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        hlt_in,
   input  logic        step_in,
   input  logic        redirect_valid_in,
   input  logic [31:0] redirect_pc_in,
   output logic [31:0] inst_addr_out,
   output logic        inst_req_out,
   input  logic [31:0] inst_data_in,
   output logic        fetch_valid_out,
   input  logic        fetch_ready_in,
   output logic [31:0] fetch_instr_out,
   output logic [31:0] fetch_pc_out
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   // Wide enough to hold queue + in-flight sum without overflow.
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 2;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_entry_t;

   logic [31:0]        pc;
   logic [MEM_LATENCY:1] vld_pipe;
   logic [31:0]        pc_pipe [MEM_LATENCY:1];

   fetch_entry_t       queue_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   q_count;
   logic [CNT_W-1:0]   inflight;
   fetch_entry_t       head;
   fetch_entry_t       last_head;
   logic               q_nonempty;
   logic               push;
   logic               pop;
   logic               step_token;
   logic               unused_pc_bits;

   // Target low bits are forced to zero; they carry no information.
   assign unused_pc_bits = ^redirect_pc_in[1:0];

   // Requests currently travelling through the memory pipeline.
   always_comb begin
      inflight = '0;
      for (int k = 1; k <= MEM_LATENCY; k++)
         inflight = inflight + CNT_W'(vld_pipe[k]);
   end

   assign q_nonempty = (q_count != '0);

   // Credits come from registered counts only: a pop this cycle frees its
   // slot for issue next cycle. Reset gating makes the request drop the
   // moment rst_in rises rather than at the next edge.
   assign inst_req_out = !rst_in && !redirect_valid_in &&
                         ((q_count + inflight) < CNT_W'(FIFO_DEPTH));
   assign inst_addr_out = pc;

   assign fetch_valid_out = !rst_in && q_nonempty && !redirect_valid_in &&
                            (!hlt_in || step_token);

   assign pop  = fetch_valid_out && fetch_ready_in;
   // A response landing in a redirect cycle belongs to the old stream.
   assign push = vld_pipe[MEM_LATENCY] && !redirect_valid_in;

   assign head = queue_mem[rd_ptr];

   // With the queue empty, the outputs keep showing the last head presented.
   assign fetch_instr_out = q_nonempty ? head.instr : last_head.instr;
   assign fetch_pc_out    = q_nonempty ? head.pc    : last_head.pc;

   // PC and in-flight {valid, pc} pipeline.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         pc       <= RESET_PC;
         vld_pipe <= '0;
         for (int k = 1; k <= MEM_LATENCY; k++)
            pc_pipe[k] <= '0;
      end else if (redirect_valid_in) begin
         pc       <= {redirect_pc_in[31:2], 2'b00};
         vld_pipe <= '0;
      end else begin
         if (inst_req_out)
            pc <= pc + 32'd4;
         vld_pipe[1] <= inst_req_out;
         pc_pipe[1]  <= pc;
         for (int k = 2; k <= MEM_LATENCY; k++) begin
            vld_pipe[k] <= vld_pipe[k-1];
            pc_pipe[k]  <= pc_pipe[k-1];
         end
      end
   end

   // Queue storage: no reset needed, occupancy is tracked by q_count.
   always_ff @(posedge clk_in) begin
      if (push)
         queue_mem[wr_ptr] <= '{instr: inst_data_in, pc: pc_pipe[MEM_LATENCY]};
   end

   // Queue pointers, occupancy and held head.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         q_count   <= '0;
         last_head <= '0;
      end else begin
         if (q_nonempty)
            last_head <= head;
         if (redirect_valid_in) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
         end else begin
            if (push)
               wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
               rd_ptr <= rd_ptr + PTR_W'(1);
            q_count <= q_count + CNT_W'(push) - CNT_W'(pop);
         end
      end
   end

   // Step token: one delivery while halted. Repeated pulses before the
   // transfer collapse into one; leaving halt discards the token.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in)
         step_token <= 1'b0;
      else if (!hlt_in)
         step_token <= 1'b0;
      else if (pop)
         step_token <= 1'b0;
      else if (step_in)
         step_token <= 1'b1;
   end

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// tb_riscv_fetch_unit
//   Three fetch-unit configurations share one stimulus stream. Each has its own
//   memory model (word = addr ^ 32'hA5A5_0000) and a reference model. The model
//   keeps the program-order list of issued-but-undelivered instructions, each
//   tagged with the cycle it becomes visible. Every cycle the monitor checks
//   request, address, valid and head outputs against that list.

module tb_riscv_fetch_unit;

   localparam int          NCFG = 3;
   localparam int          LAT [NCFG] = '{1, 3, 4};
   localparam int          DEP [NCFG] = '{4, 4, 8};
   localparam logic [31:0] RPC [NCFG] = '{32'h0000_0000, 32'hFFFF_FFF8, 32'h0000_1000};

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      int          rdy;
   } exp_t;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b0;
   logic        hlt_in = 1'b0;
   logic        step_in = 1'b0;
   logic        redirect_valid_in = 1'b0;
   logic [31:0] redirect_pc_in = '0;
   logic        fetch_ready_in = 1'b0;
   logic        done = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk_in = ~clk_in;

   task automatic chk(input string name, input int cfg_i,
                      input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cfg%0d got %h expected %h at %0t", name, cfg_i, act, exp, $time);
      end
   endtask

   for (genvar g = 0; g < NCFG; g++) begin : cfg
      localparam int          L = LAT[g];
      localparam int          D = DEP[g];
      localparam logic [31:0] R = RPC[g];

      logic [31:0] inst_addr, inst_data, instr, pcv;
      logic        req, valid;

      riscv_fetch_unit #(.RESET_PC(R), .MEM_LATENCY(L), .FIFO_DEPTH(D)) u_dut (
         .clk_in            (clk_in),
         .rst_in            (rst_in),
         .hlt_in            (hlt_in),
         .step_in           (step_in),
         .redirect_valid_in (redirect_valid_in),
         .redirect_pc_in    (redirect_pc_in),
         .inst_addr_out     (inst_addr),
         .inst_req_out      (req),
         .inst_data_in      (inst_data),
         .fetch_valid_out   (valid),
         .fetch_ready_in    (fetch_ready_in),
         .fetch_instr_out   (instr),
         .fetch_pc_out      (pcv)
      );

      // Fixed-latency memory; it knows nothing of resets or redirects.
      logic [31:0] ma [L];
      logic [L-1:0] mv = '0;
      always @(posedge clk_in) begin
         ma[0] <= inst_addr;
         mv[0] <= req;
         for (int k = 1; k < L; k++) begin
            ma[k] <= ma[k-1];
            mv[k] <= mv[k-1];
         end
      end
      assign inst_data = mv[L-1] ? (ma[L-1] ^ 32'hA5A5_0000) : 32'hDEAD_BEEF;

      exp_t        q[$];
      logic [31:0] m_pc = R;
      logic        tok = 1'b0;
      logic [31:0] last_pc = '0;
      logic [31:0] last_in = '0;
      int          cyc = 0;
      int          delivered = 0;

      always @(negedge clk_in) begin
         if (rst_in) begin
            chk("rst_req",   g, 32'(req),   32'd0);
            chk("rst_valid", g, 32'(valid), 32'd0);
            chk("rst_addr",  g, inst_addr,  R);
            chk("rst_instr", g, instr,      32'd0);
            chk("rst_pc",    g, pcv,        32'd0);
            q.delete();
            m_pc = R;
            tok = 1'b0;
            last_pc = '0;
            last_in = '0;
         end else begin
            logic exp_req, avail, exp_valid, xfer;
            exp_req   = !redirect_valid_in && (q.size() < D);
            avail     = (q.size() > 0) && (q[0].rdy <= cyc);
            exp_valid = avail && !redirect_valid_in && (!hlt_in || tok);
            if (avail) begin
               last_pc = q[0].pc;
               last_in = q[0].instr;
            end
            chk("req",        g, 32'(req),   32'(exp_req));
            chk("addr",       g, inst_addr,  m_pc);
            chk("valid",      g, 32'(valid), 32'(exp_valid));
            chk("head_pc",    g, pcv,        last_pc);
            chk("head_instr", g, instr,      last_in);
            xfer = exp_valid && fetch_ready_in;
            if (redirect_valid_in) begin
               q.delete();
               m_pc = {redirect_pc_in[31:2], 2'b00};
            end else begin
               if (xfer) begin
                  void'(q.pop_front());
                  delivered++;
               end
               if (exp_req) begin
                  q.push_back('{m_pc, m_pc ^ 32'hA5A5_0000, cyc + L + 1});
                  m_pc = m_pc + 32'd4;
               end
            end
            if (!hlt_in)   tok = 1'b0;
            else if (xfer) tok = 1'b0;
            else if (step_in) tok = 1'b1;
         end
         cyc++;
      end

      // A response written into a full queue would mean the credit rule broke.
      always @(negedge clk_in) begin
         if (!rst_in && u_dut.push)
            chk("push_full", g, 32'(u_dut.q_count >= D[$bits(u_dut.q_count)-1:0]), 32'd0);
      end

      // Reset acts immediately, not at the next edge.
      always @(posedge rst_in) begin
         #1;
         chk("async_req",   g, 32'(req),   32'd0);
         chk("async_valid", g, 32'(valid), 32'd0);
         chk("async_addr",  g, inst_addr,  R);
      end

      always @(posedge done)
         chk("delivered_some", g, 32'(delivered > 100), 32'd1);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   initial begin
      #1 rst_in = 1'b1;
      tick(3);
      rst_in = 1'b0;

      // streaming
      fetch_ready_in = 1'b1;
      tick(20);

      // backpressure from reset, then release
      rst_in = 1'b1;
      fetch_ready_in = 1'b0;
      tick(1);
      rst_in = 1'b0;
      tick(12);
      fetch_ready_in = 1'b1;
      tick(20);

      // redirect to an unaligned target mid-stream, then back-to-back
      redirect_valid_in = 1'b1;
      redirect_pc_in = 32'h0000_0103;
      tick(1);
      redirect_valid_in = 1'b0;
      tick(15);
      redirect_valid_in = 1'b1;
      redirect_pc_in = 32'h0000_0200;
      tick(1);
      redirect_pc_in = 32'h0000_0302;
      tick(1);
      redirect_valid_in = 1'b0;
      tick(15);

      // halt with single steps
      hlt_in = 1'b1;
      tick(12);
      step_in = 1'b1;
      tick(1);
      step_in = 1'b0;
      tick(5);
      fetch_ready_in = 1'b0;
      step_in = 1'b1;
      tick(1);
      step_in = 1'b0;
      tick(1);
      step_in = 1'b1;
      tick(1);
      step_in = 1'b0;
      tick(2);
      fetch_ready_in = 1'b1;
      tick(5);
      redirect_valid_in = 1'b1;
      redirect_pc_in = 32'h0000_0400;
      step_in = 1'b1;
      tick(1);
      redirect_valid_in = 1'b0;
      step_in = 1'b0;
      tick(8);
      hlt_in = 1'b0;
      tick(5);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         fetch_ready_in    = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 49) == 0) hlt_in = ~hlt_in;
         step_in           = ($urandom_range(0, 5) == 0);
         redirect_valid_in = ($urandom_range(0, 29) == 0);
         redirect_pc_in    = $urandom;
         tick(1);
      end

      // asynchronous reset between edges while streaming
      hlt_in = 1'b0;
      step_in = 1'b0;
      redirect_valid_in = 1'b0;
      fetch_ready_in = 1'b1;
      tick(10);
      #2 rst_in = 1'b1;
      tick(2);
      rst_in = 1'b0;
      tick(30);

      done = 1'b1;
      #2;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
